// File: rtl/pixel_tick_gen.sv
// ---------------------------------------------------------------------------
// pixel_tick_gen
//  Clock-enable generator for the VGA pixel/character timing path.
//  Emits a one-cycle `tick` every `eff` enabled clocks and a `tick_sub`
//  on every SUB_DIV-th tick. The divide value can be reloaded at runtime
//  with a div_load/div_ack handshake. A reload takes effect only at a
//  period boundary, so the running period always finishes at its old length.
//
//  Optional feature macro: FRAC_DIV_EN
//    When defined, a fractional accumulator stretches selected periods
//    by one clock. The average period is then div + frac/2^FRAC_W.
//
// Ports
//  clk         in   1       system clock
//  reset       in   1       asynchronous, active-high
//  enable      in   1       count enable; low freezes all counters
//  div_value   in   CNT_W   requested divide value (0 behaves as 1)
//  frac_value  in   FRAC_W  fractional part, captured with div_load
//                           (FRAC_DIV_EN only)
//  div_load    in   1       one-cycle request to capture div_value
//  div_ack     out  1       one-cycle pulse: the pending value is now active
//  tick        out  1       pixel enable pulse
//  tick_sub    out  1       character enable pulse, coincident with a tick
//  phase       out  CNT_W   current period counter value
// ---------------------------------------------------------------------------
module pixel_tick_gen #(
  parameter int CNT_W     = 8,
  parameter int DIV_RESET = 4,
  parameter int SUB_DIV   = 8,
  parameter int FRAC_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] div_value,
`ifdef FRAC_DIV_EN
  input  logic [FRAC_W-1:0] frac_value,
`endif
  input  logic             div_load,
  output logic             div_ack,
  output logic             tick,
  output logic             tick_sub,
  output logic [CNT_W-1:0] phase
);

  localparam int               SUB_W    = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_DIV - 1);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RESET);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] pend_val_q, pend_val_d;
  logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
  logic             pend_q, pend_d;
  logic             div_ack_q, div_ack_d;

  logic             stretch;   // current period is one clock longer
  logic [CNT_W:0]   eff;       // one extra bit: a stretched max period is 2^CNT_W
  logic [CNT_W:0]   eff_last;
  logic             tick_int;
  logic             apply;

  // Period length and terminal-count detection
  always_comb begin
    eff = (div_cur_q == '0) ? {{CNT_W{1'b0}}, 1'b1} : {1'b0, div_cur_q};
    eff = eff + {{CNT_W{1'b0}}, stretch};
    eff_last = eff - {{CNT_W{1'b0}}, 1'b1};
    tick_int = enable & ({1'b0, cnt_q} == eff_last);
    // A load that lands on the wrap cycle applies at that same wrap.
    apply = tick_int & (pend_q | div_load);
  end

  always_comb begin
    cnt_d      = cnt_q;
    sub_cnt_d  = sub_cnt_q;
    div_cur_d  = div_cur_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    div_ack_d  = apply;

    // Loads are captured even while enable is low. They wait for a tick.
    if (div_load) begin
      pend_val_d = div_value;
      pend_d     = 1'b1;
    end

    if (enable) begin
      cnt_d = tick_int ? '0 : cnt_q + 1'b1;
    end

    // sub_cnt keeps running across reloads to keep the character grid aligned.
    if (tick_int) begin
      sub_cnt_d = (sub_cnt_q == SUB_LAST) ? '0 : sub_cnt_q + 1'b1;
    end

    if (apply) begin
      div_cur_d = div_load ? div_value : pend_val_q;
      pend_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      sub_cnt_q  <= '0;
      div_cur_q  <= DIV_INIT;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      div_ack_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sub_cnt_q  <= sub_cnt_d;
      div_cur_q  <= div_cur_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      div_ack_q  <= div_ack_d;
    end
  end

`ifdef FRAC_DIV_EN
  logic [FRAC_W-1:0] frac_cur_q, frac_cur_d;
  logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              stretch_q, stretch_d;

  assign stretch = stretch_q;

  always_comb begin
    frac_cur_d  = frac_cur_q;
    pend_frac_d = pend_frac_q;
    acc_d       = acc_q;
    stretch_d   = stretch_q;

    if (div_load) begin
      pend_frac_d = frac_value;
    end

    // The period that just ended accumulates with the fraction it ran under.
    // A carry out lengthens the next period by one clock.
    if (tick_int) begin
      {stretch_d, acc_d} = {1'b0, acc_q} + {1'b0, frac_cur_q};
    end

    if (apply) begin
      frac_cur_d = div_load ? frac_value : pend_frac_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frac_cur_q  <= '0;
      pend_frac_q <= '0;
      acc_q       <= '0;
      stretch_q   <= 1'b0;
    end else begin
      frac_cur_q  <= frac_cur_d;
      pend_frac_q <= pend_frac_d;
      acc_q       <= acc_d;
      stretch_q   <= stretch_d;
    end
  end
`else
  // Without fractional division the period is never stretched.
  // This all-zero vector keeps FRAC_W referenced in this build.
  logic [FRAC_W-1:0] no_frac;
  assign no_frac = '0;
  assign stretch = |no_frac;
`endif

  assign tick     = tick_int;
  assign tick_sub = tick_int & (sub_cnt_q == SUB_LAST);
  assign div_ack  = div_ack_q;
  assign phase    = cnt_q;

endmodule

// File: tb/tb_pixel_tick_gen.sv
module tb_pixel_tick_gen;

  localparam int CNT_W     = 8;
  localparam int DIV_RESET = 4;
  localparam int SUB_DIV   = 8;
  localparam int FRAC_W    = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic [CNT_W-1:0] div_value = '0;
  logic [FRAC_W-1:0] frac_value = '0;
  logic             div_load = 1'b0;
  logic             div_ack;
  logic             tick;
  logic             tick_sub;
  logic [CNT_W-1:0] phase;

  int checks = 0;
  int errors = 0;

  // Reference model, written in terms of periods and tick counts.
  int m_elapsed;   // enabled clocks already spent in the current period
  int m_base;      // divide value in force (0 is treated as 1)
  int m_pend;      // requested divide value waiting for a boundary, -1 = none
  int m_pfrac;
  int m_frac;
  int m_acc;
  int m_stretch;
  int m_ticks;     // ticks since reset
  int m_ack;       // div_ack expected during this cycle

  always #5 clk = ~clk;

  pixel_tick_gen #(
    .CNT_W(CNT_W), .DIV_RESET(DIV_RESET), .SUB_DIV(SUB_DIV), .FRAC_W(FRAC_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .div_value(div_value),
`ifdef FRAC_DIV_EN
    .frac_value(frac_value),
`endif
    .div_load(div_load),
    .div_ack(div_ack),
    .tick(tick),
    .tick_sub(tick_sub),
    .phase(phase)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_elapsed = 0; m_base = DIV_RESET; m_pend = -1; m_pfrac = 0;
    m_frac = 0; m_acc = 0; m_stretch = 0; m_ticks = 0; m_ack = 0;
  endtask

  // Reset is asserted asynchronously, away from any clock edge.
  // The outputs must clear at once, before any clock edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_tick", int'(tick), 0);
    chk("rst_sub", int'(tick_sub), 0);
    chk("rst_ack", int'(div_ack), 0);
    chk("rst_phase", int'(phase), 0);
    div_load = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One clock. Inputs change at the falling edge and outputs are checked 1 ns later.
  task automatic cyc(input bit en, input bit ld, input int dv, input int fv);
    bit exp_tick, exp_sub;
    int eff, next_ack, carry;
    enable = en; div_load = ld;
    div_value = CNT_W'(dv); frac_value = FRAC_W'(fv);
    #1;
    eff = ((m_base == 0) ? 1 : m_base) + m_stretch;
    exp_tick = en && (m_elapsed + 1 == eff);
    exp_sub  = exp_tick && ((m_ticks % SUB_DIV) == SUB_DIV - 1);
    $display("t=%0t en=%0b ld=%0b dv=%0d phase=%0d tick=%0b sub=%0b ack=%0b",
             $time, en, ld, dv, phase, tick, tick_sub, div_ack);
    chk("phase", int'(phase), m_elapsed);
    chk("tick", int'(tick), int'(exp_tick));
    chk("tick_sub", int'(tick_sub), int'(exp_sub));
    chk("div_ack", int'(div_ack), m_ack);
    next_ack = 0;
    if (ld) begin m_pend = dv; m_pfrac = fv; end
    if (exp_tick) begin
      m_ticks++;
      m_elapsed = 0;
`ifdef FRAC_DIV_EN
      carry = (m_acc + m_frac) >= (1 << FRAC_W);
      m_acc = (m_acc + m_frac) % (1 << FRAC_W);
      m_stretch = carry;
`else
      carry = 0;
      m_stretch = carry;
`endif
      if (m_pend >= 0) begin
        m_base = m_pend; m_frac = m_pfrac; m_pend = -1; next_ack = 1;
      end
    end else if (en) begin
      m_elapsed++;
    end
    m_ack = next_ack;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int tick_gap, last_tick;
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset state with enable high: the first tick comes on the 4th clock.
    repeat (12) cyc(1, 0, 0, 0);

    // Load 6 at phase 1: the old period of 4 still completes.
    for (int k = 0; k < 300 && m_elapsed != 1; k++) cyc(1, 0, 0, 0);
    cyc(1, 1, 6, 0);
    repeat (20) cyc(1, 0, 0, 0);

    // Two loads in one period: the last one wins and gives a single ack.
    for (int k = 0; k < 300 && m_elapsed != 0; k++) cyc(1, 0, 0, 0);
    cyc(1, 1, 5, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 7, 0);
    repeat (25) cyc(1, 0, 0, 0);

    // A divide value of 0 gives a tick on every clock.
    cyc(1, 1, 0, 0);
    repeat (12) cyc(1, 0, 0, 0);

    // Back to 4, then hold enable low for 5 clocks mid-period.
    cyc(1, 1, 4, 0);
    repeat (6) cyc(1, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0);
    repeat (8) cyc(1, 0, 0, 0);

    // With a period of 4, the character tick arrives every 32 clocks.
    last_tick = -1; tick_gap = 0;
    for (int k = 0; k < 70; k++) begin
      if (tick_sub === 1'b1) begin
        if (last_tick >= 0) chk("sub_gap", k - last_tick, 32);
        last_tick = k;
      end
      cyc(1, 0, 0, 0);
    end

    // Reset at phase 2 with a load pending: the load is discarded.
    for (int k = 0; k < 300 && m_elapsed != 1; k++) cyc(1, 0, 0, 0);
    cyc(1, 1, 9, 0);
    do_reset();
    repeat (14) cyc(1, 0, 0, 0);

`ifdef FRAC_DIV_EN
    // Divide 4 with fraction 8/16: periods alternate 4 and 5.
    cyc(1, 1, 4, 8);
    repeat (40) cyc(1, 0, 0, 0);
`endif

    // Randomised traffic
    for (int k = 0; k < 2500; k++) begin
      bit en, ld;
      int dv, fv;
      en = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 11) == 0);
      dv = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 9);
      fv = $urandom_range(0, 15);
      if ($urandom_range(0, 399) == 0) do_reset();
      else cyc(en, ld, dv, fv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
